serial_adder: RTL

Parametrised bit-serial adder/subtractor: the sequential successor to the board's combinational full adder. It reuses a single full-adder cell across WIDTH clock cycles to add or subtract two WIDTH-bit operands taken from the switch bank, then presents sum, carry and overflow on the LEDs. The block sits between the switch/button synchroniser and the LED driver in the Basys3 logic tutorial top level, and is controlled by a start/busy/done handshake.

---
 rtl/serial_adder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder
// ----------------------------------------------------------------------------
// Bit-serial adder/subtractor. One full-adder cell is reused over WIDTH clock
// cycles to add (a+b) or subtract (a-b) two WIDTH-bit operands. It is the
// sequential follow-on to the tutorial's combinational full adder. Results are
// presented on sum/cout/ovf and held until the next operation completes.
//
// Subtraction is done as a + ~b + 1. B is inverted on capture and the carry is
// seeded with the mode bit.
//
// Parameters:
//   WIDTH   operand/result width in bits (2..32), default 8
//
// Ports:
//   clk     in   system clock, rising-edge active
//   rst_n   in   asynchronous active-low reset
//   start   in   request a new operation (honoured in IDLE or DONE only)
//   mode    in   0 = add, 1 = subtract; captured together with start
//   a, b    in   WIDTH-bit operands; captured together with start
//   busy    out  high while the serial add is running
//   done    out  single-cycle pulse when a fresh result is valid
//   sum     out  WIDTH-bit result of the last completed operation
//   cout    out  carry out of the MSB (subtract: 1 = no borrow, a >= b)
//   ovf     out  signed two's-complement overflow of the last result
//
// Build option:
//   SERIAL_ADDER_OVF_EN  when defined, ovf is computed and registered.
//                        When undefined, ovf is tied low and no overflow
//                        storage is built.
// ============================================================================

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // The bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT            r_state;
   stateT            w_nextState;

   logic [WIDTH-1:0] r_opA;
   logic [WIDTH-1:0] r_opB;
   logic [WIDTH-1:0] r_partial;
   logic             r_carry;
   logic [CW-1:0]    r_count;

   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_capture;
   logic             w_lastBit;
   logic             w_sumBit;
   logic             w_carryOut;
   logic [WIDTH-1:0] w_finalSum;

   // A start request is only honoured outside RUN.
   // In DONE it gives the back-to-back case.
   assign w_capture = start && ((r_state == IDLE) || (r_state == DONE));

   // The final RUN cycle processes the MSB and latches the results.
   assign w_lastBit = (r_state == RUN) && (r_count == LAST_BIT);

   // The single shared full-adder cell works on the operand LSBs.
   assign w_sumBit   = r_opA[0] ^ r_opB[0] ^ r_carry;
   assign w_carryOut = (r_opA[0] & r_opB[0]) | (r_carry & (r_opA[0] ^ r_opB[0]));

   // Sum bits enter at the MSB and move right.
   // After WIDTH shifts, bit 0 lands in position 0.
   assign w_finalSum = {w_sumBit, r_partial[WIDTH-1:1]};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake decode.
   // busy covers exactly the WIDTH serial cycles.
   // done marks the one cycle spent in DONE.
   always_comb begin
      w_nextState = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (r_count == LAST_BIT) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               w_nextState = RUN;
            end else begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Serial datapath.
   // On capture, B is inverted for subtraction, and the carry is seeded with
   // the mode bit to supply the +1 of the two's complement.
   // During RUN, both operands shift right one bit per cycle.
   // After capture the inputs are no longer looked at, so a, b and mode may
   // change freely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opA     <= '0;
         r_opB     <= '0;
         r_partial <= '0;
         r_carry   <= 1'b0;
         r_count   <= '0;
      end else if (w_capture) begin
         r_opA     <= a;
         r_opB     <= b ^ {WIDTH{mode}};
         r_partial <= '0;
         r_carry   <= mode;
         r_count   <= '0;
      end else if (r_state == RUN) begin
         r_opA     <= r_opA >> 1;
         r_opB     <= r_opB >> 1;
         r_partial <= w_finalSum;
         r_carry   <= w_carryOut;
         if (w_lastBit) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + CW'(1);
         end
      end
   end

   // Result registers.
   // They update only on the MSB cycle, so partial sums never reach the LEDs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else if (w_lastBit) begin
         r_sum  <= w_finalSum;
         r_cout <= w_carryOut;
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   // On the MSB cycle, r_carry still holds the carry into the MSB.
   // Signed overflow is that carry XOR the carry out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_lastBit) begin
         r_ovf <= r_carry ^ w_carryOut;
      end
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

endmodule
